dma_job_arbiter: RTL and testbench



---
 rtl/dma_job_arb_pkg.sv | 34 +++
 rtl/dma_job_arb_order_fifo.sv | 63 ++++++
 rtl/dma_job_arbiter.sv | 158 +++++++++++++++
 tb/tb_dma_job_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_job_arb_pkg.sv
// Shared types and helpers for the DMA job arbiter: FSM state encoding,
// requester-count ceiling and the round-robin pick function.
package dma_job_arb_pkg;

    localparam int MaxNumReq = 8;
    localparam int MaxIdxW   = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // First set bit of valid at or after ptr, scanning cyclically over num_req entries.
    function automatic logic [MaxIdxW-1:0] rr_pick(
        input logic [MaxNumReq-1:0] valid,
        input logic [MaxIdxW-1:0]   ptr,
        input int                   num_req
    );
        logic [MaxIdxW-1:0] pick;
        logic               found;
        int                 idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MaxNumReq; i++) begin
            idx = (int'(ptr) + i) % num_req;
            if (i < num_req && !found && valid[idx[MaxIdxW-1:0]]) begin
                pick  = idx[MaxIdxW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dma_job_arb_order_fifo.sv
// In-order FIFO of granted requester indices; the head names the owner of
// the next backend response.
module dma_job_arb_order_fifo
    import dma_job_arb_pkg::*;
#(
    parameter int Depth  = 4,
    parameter int Width  = 1,
    localparam int PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int UsageW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [Width-1:0]  push_data_i,
    input  logic              pop_i,
    output logic [Width-1:0]  head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [UsageW-1:0] usage_o
);

    logic [Width-1:0]  mem_q [Depth];
    logic [PtrW-1:0]   wr_q, rd_q;
    logic [UsageW-1:0] usage_q, usage_d;

    always_comb begin
        usage_d = usage_q;
        if (push_i && !pop_i) begin
            usage_d = usage_q + UsageW'(1);
        end else if (pop_i && !push_i) begin
            usage_d = usage_q - UsageW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            usage_q <= '0;
        end else begin
            usage_q <= usage_d;
            if (push_i) begin
                wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + PtrW'(1);
            end
        end
    end

    // Storage needs no reset: usage_q alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (usage_q == '0);
    assign full_o  = (usage_q == UsageW'(Depth));
    assign usage_o = usage_q;

endmodule

// File: rtl/dma_job_arbiter.sv
// Round-robin arbiter sharing one iDMA backend between NumReq requesters,
// with in-order response routing. Optional retired-job counters: DMA_JOB_ARB_STATS_EN.
module dma_job_arbiter
    import dma_job_arb_pkg::*;
#(
    parameter int  NumReq      = 2,
    parameter int  MaxInFlight = 4,
    parameter type idma_req_t  = logic,
    parameter type idma_rsp_t  = logic,
    localparam int ReqW   = $bits(idma_req_t),
    localparam int RspW   = $bits(idma_rsp_t),
    localparam int CntW   = $clog2(MaxInFlight + 1),
    localparam int IdxW   = $clog2(NumReq)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq*ReqW-1:0] req_i,
    input  logic [NumReq-1:0]      req_valid_i,
    output logic [NumReq-1:0]      req_ready_o,
    output logic [NumReq*RspW-1:0] rsp_o,
    output logic [NumReq-1:0]      rsp_valid_o,
    input  logic [NumReq-1:0]      rsp_ready_i,
    output logic [ReqW-1:0]        be_req_o,
    output logic                   be_valid_o,
    input  logic                   be_ready_i,
    input  logic [RspW-1:0]        be_rsp_i,
    input  logic                   be_rsp_valid_i,
    output logic                   be_rsp_ready_o,
    output logic                   busy_o,
    output logic [NumReq*CntW-1:0] outstanding_o,
    output logic [NumReq*32-1:0]   jobs_done_o
);

    // Handshakes: a beat transfers on a cycle where valid & ready are both high;
    // once valid is raised its payload and target stay fixed until that cycle.

    arb_state_e         state_q;
    logic [IdxW-1:0]    grant_q, rr_q, pick;
    logic               locked, accept, retire;
    logic [IdxW-1:0]    head;
    logic               fifo_full, fifo_empty;
    logic [CntW-1:0]    fifo_usage;
    logic [CntW-1:0]    cnt_q [NumReq];
    logic [CntW-1:0]    cnt_d [NumReq];

    assign pick = IdxW'(rr_pick(MaxNumReq'(req_valid_i), MaxIdxW'(rr_q), NumReq));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Full blocks the lock even if a retire frees a slot this cycle.
                    if (|req_valid_i && !fifo_full) begin
                        state_q <= ST_LOCKED;
                        grant_q <= pick;
                    end
                end
                ST_LOCKED: begin
                    if (be_ready_i) begin
                        state_q <= ST_IDLE;
                        rr_q    <= (int'(grant_q) == NumReq - 1) ? '0 : grant_q + IdxW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign locked = (state_q == ST_LOCKED) && !rst_i;
    assign accept = locked && be_ready_i;
    assign retire = be_rsp_valid_i && be_rsp_ready_o;

    dma_job_arb_order_fifo #(
        .Depth (MaxInFlight),
        .Width (IdxW)
    ) u_order_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (accept),
        .push_data_i (grant_q),
        .pop_i       (retire),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .usage_o     (fifo_usage)
    );

    always_comb begin
        be_req_o       = '0;
        req_ready_o    = '0;
        rsp_valid_o    = '0;
        be_rsp_ready_o = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant_q == IdxW'(i)) begin
                be_req_o       = req_i[i*ReqW +: ReqW];
                req_ready_o[i] = accept;
            end
            if (head == IdxW'(i) && !fifo_empty && !rst_i) begin
                rsp_valid_o[i] = be_rsp_valid_i;
                be_rsp_ready_o = rsp_ready_i[i];
            end
        end
    end

    assign rsp_o      = {NumReq{be_rsp_i}};
    assign be_valid_o = locked;
    assign busy_o     = !rst_i && (locked || fifo_usage != '0);

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && grant_q == IdxW'(i) && !(retire && head == IdxW'(i))) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (retire && head == IdxW'(i) && !(accept && grant_q == IdxW'(i))) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumReq; i++) begin
            cnt_q[i] <= rst_i ? '0 : cnt_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            outstanding_o[i*CntW +: CntW] = cnt_q[i];
        end
    end

`ifdef DMA_JOB_ARB_STATS_EN
    logic [31:0] done_q [NumReq];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumReq; i++) begin
            if (rst_i) begin
                done_q[i] <= '0;
            end else if (retire && head == IdxW'(i)) begin
                done_q[i] <= done_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            jobs_done_o[i*32 +: 32] = done_q[i];
        end
    end
`else
    assign jobs_done_o = '0;
`endif

endmodule

// File: tb/tb_dma_job_arbiter.sv
// Self-checking bench for dma_job_arbiter (NumReq=2, MaxInFlight=4, 8-bit job/response).
module tb_dma_job_arbiter;

    localparam int N  = 2;
    localparam int CW = 3;
    localparam int IW = 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N*8-1:0]    req_i;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*8-1:0]    rsp_o;
    logic [N-1:0]      rsp_valid_o;
    logic [N-1:0]      rsp_ready_i;
    logic [7:0]        be_req_o;
    logic              be_valid_o;
    logic              be_ready_i;
    logic [7:0]        be_rsp_i;
    logic              be_rsp_valid_i;
    logic              be_rsp_ready_o;
    logic              busy_o;
    logic [N*CW-1:0]   outstanding_o;
    logic [N*32-1:0]   jobs_done_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [IW-1:0] exp_q[$];

    dma_job_arbiter #(
        .NumReq      (N),
        .MaxInFlight (4),
        .idma_req_t  (logic [7:0]),
        .idma_rsp_t  (logic [7:0])
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .rsp_o          (rsp_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .be_req_o       (be_req_o),
        .be_valid_o     (be_valid_o),
        .be_ready_i     (be_ready_i),
        .be_rsp_i       (be_rsp_i),
        .be_rsp_valid_i (be_rsp_valid_i),
        .be_rsp_ready_o (be_rsp_ready_o),
        .busy_o         (busy_o),
        .outstanding_o  (outstanding_o),
        .jobs_done_o    (jobs_done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return -1;
    endfunction

    task automatic drain();
        int cyc;
        tick();
        req_valid_i    = '0;
        be_ready_i     = 1'b0;
        be_rsp_valid_i = 1'b1;
        rsp_ready_i    = '1;
        cyc = 0;
        while (outstanding_o != '0 && cyc < 20) begin
            tick();
            cyc++;
        end
        be_rsp_valid_i = 1'b0;
        #1;
        chk_cnt++;
        if (outstanding_o !== '0 || busy_o !== 1'b0)
            $display("FAIL drain: outstanding=%h busy=%b, want 0/0", outstanding_o, busy_o);
        else pass_cnt++;
    endtask

    task automatic issue_job(input int idx);
        int  n;
        logic got;
        req_valid_i    = '0;
        req_valid_i[idx] = 1'b1;
        be_ready_i     = 1'b1;
        be_rsp_valid_i = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            tick();
            n++;
            if (be_valid_o && req_ready_o[idx]) got = 1'b1;
        end
        chk_cnt++;
        if (!got) $display("FAIL issue_accept: req %0d not accepted within 10 cycles", idx);
        else pass_cnt++;
        tick();
        req_valid_i = '0;
        be_ready_i  = 1'b0;
        if (got) exp_q.push_back(IW'(idx));
    endtask

    task automatic test_reset();
        rst_i          = 1'b1;
        req_i          = '0;
        req_valid_i    = 2'b11;
        rsp_ready_i    = 2'b11;
        be_ready_i     = 1'b1;
        be_rsp_i       = '0;
        be_rsp_valid_i = 1'b1;
        repeat (3) tick();
        chk_cnt++;
        if (be_valid_o !== 1'b0 || req_ready_o !== 2'b00 || busy_o !== 1'b0 ||
            be_rsp_ready_o !== 1'b0 || rsp_valid_o !== 2'b00)
            $display("FAIL reset_hold: be_valid=%b req_ready=%b busy=%b be_rsp_ready=%b rsp_valid=%b, want all 0",
                     be_valid_o, req_ready_o, busy_o, be_rsp_ready_o, rsp_valid_o);
        else pass_cnt++;
        rst_i          = 1'b0;
        req_valid_i    = '0;
        be_rsp_valid_i = 1'b0;
        #1;
        chk_cnt++;
        if (outstanding_o !== '0 || jobs_done_o !== '0 || busy_o !== 1'b0)
            $display("FAIL reset_state: outstanding=%h jobs_done=%h busy=%b, want 0", outstanding_o, jobs_done_o, busy_o);
        else pass_cnt++;
    endtask

    task automatic test_rr_alternate();
        int cyc;
        int g;
        logic [IW-1:0] e;
        logic [7:0] want;
        req_i          = {8'hB1, 8'hA0};
        req_valid_i    = 2'b11;
        be_ready_i     = 1'b1;
        be_rsp_i       = 8'h11;
        be_rsp_valid_i = 1'b1;
        rsp_ready_i    = 2'b11;
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(IW'(i % 2));
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 40) begin
            tick();
            cyc++;
            if (be_valid_o) begin
                e    = exp_q.pop_front();
                g    = oh_idx(req_ready_o);
                want = (e == 1'b1) ? 8'hB1 : 8'hA0;
                chk_cnt++;
                if (g !== int'(e) || be_req_o !== want)
                    $display("FAIL rr_grant: grant=%0d be_req=%h, want grant=%0d be_req=%h", g, be_req_o, e, want);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL rr_timeout: %0d grants missing", exp_q.size());
        else pass_cnt++;
        drain();
    endtask

    task automatic test_hold();
        logic [IW-1:0] e;
        req_i          = {8'h5C, 8'h3A};
        req_valid_i    = 2'b10;
        be_ready_i     = 1'b0;
        be_rsp_valid_i = 1'b0;
        exp_q.delete();
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_cnt++;
            if (be_valid_o !== 1'b1 || be_req_o !== 8'h5C || req_ready_o !== 2'b00)
                $display("FAIL hold_req1: be_valid=%b be_req=%h req_ready=%b, want 1/5c/00", be_valid_o, be_req_o, req_ready_o);
            else pass_cnt++;
        end
        req_valid_i = 2'b11;
        #1;
        chk_cnt++;
        if (be_req_o !== 8'h5C) $display("FAIL no_regrant: be_req=%h, want 5c", be_req_o);
        else pass_cnt++;
        be_ready_i = 1'b1;
        #1;
        e = exp_q.pop_front();
        chk_cnt++;
        if (oh_idx(req_ready_o) !== int'(e)) $display("FAIL accept_req1: req_ready=%b, want grant %0d", req_ready_o, e);
        else pass_cnt++;
        tick();
        req_valid_i = 2'b01;
        tick();
        e = exp_q.pop_front();
        chk_cnt++;
        if (oh_idx(req_ready_o) !== int'(e) || be_req_o !== 8'h3A)
            $display("FAIL next_req0: req_ready=%b be_req=%h, want grant %0d be_req 3a", req_ready_o, be_req_o, e);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_full();
        int cyc;
        req_i          = {8'h00, 8'h77};
        req_valid_i    = 2'b01;
        be_ready_i     = 1'b1;
        be_rsp_valid_i = 1'b0;
        cyc = 0;
        while (outstanding_o[0 +: CW] != 3'd4 && cyc < 30) begin
            tick();
            cyc++;
        end
        repeat (2) tick();
        chk_cnt++;
        if (outstanding_o[0 +: CW] !== 3'd4 || be_valid_o !== 1'b0 || busy_o !== 1'b1)
            $display("FAIL full_block: outstanding0=%0d be_valid=%b busy=%b, want 4/0/1", outstanding_o[0 +: CW], be_valid_o, busy_o);
        else pass_cnt++;
        be_rsp_valid_i = 1'b1;
        rsp_ready_i    = 2'b01;
        #1;
        chk_cnt++;
        if (be_rsp_ready_o !== 1'b1) $display("FAIL retire_ready: be_rsp_ready=%b, want 1", be_rsp_ready_o);
        else pass_cnt++;
        tick();
        be_rsp_valid_i = 1'b0;
        chk_cnt++;
        if (be_valid_o !== 1'b0 || outstanding_o[0 +: CW] !== 3'd3)
            $display("FAIL same_cycle_block: be_valid=%b outstanding0=%0d, want 0/3", be_valid_o, outstanding_o[0 +: CW]);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (be_valid_o !== 1'b1 || be_req_o !== 8'h77)
            $display("FAIL present_after_retire: be_valid=%b be_req=%h, want 1/77", be_valid_o, be_req_o);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_order();
        logic [IW-1:0] e;
        logic [7:0]    d;
        exp_q.delete();
        issue_job(1);
        issue_job(0);
        issue_job(1);
        rsp_ready_i    = 2'b11;
        be_rsp_valid_i = 1'b1;
        for (int r = 0; r < 3; r++) begin
            d        = 8'hD0 + 8'(r);
            be_rsp_i = d;
            if (r == 1) begin
                rsp_ready_i = 2'b10;
                #1;
                chk_cnt++;
                if (be_rsp_ready_o !== 1'b0 || oh_idx(rsp_valid_o) !== int'(exp_q[0]))
                    $display("FAIL rsp_stall: be_rsp_ready=%b rsp_valid=%b, want 0 and head %0d", be_rsp_ready_o, rsp_valid_o, exp_q[0]);
                else pass_cnt++;
                tick();
                chk_cnt++;
                if (outstanding_o[0 +: CW] !== 3'd1)
                    $display("FAIL stall_hold: outstanding0=%0d, want 1", outstanding_o[0 +: CW]);
                else pass_cnt++;
                rsp_ready_i = 2'b11;
            end
            #1;
            e = exp_q.pop_front();
            chk_cnt++;
            if (oh_idx(rsp_valid_o) !== int'(e) || rsp_o[int'(e)*8 +: 8] !== d || be_rsp_ready_o !== 1'b1)
                $display("FAIL rsp_route: rsp_valid=%b data=%h be_rsp_ready=%b, want owner %0d data %h ready 1",
                         rsp_valid_o, rsp_o[int'(e)*8 +: 8], be_rsp_ready_o, e, d);
            else pass_cnt++;
            tick();
        end
        be_rsp_valid_i = 1'b0;
        chk_cnt++;
        if (outstanding_o !== '0 || busy_o !== 1'b0)
            $display("FAIL order_drained: outstanding=%h busy=%b, want 0/0", outstanding_o, busy_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        exp_q.delete();
        issue_job(0);
        issue_job(1);
        chk_cnt++;
        if (outstanding_o !== {3'd1, 3'd1}) $display("FAIL pre_reset_cnt: outstanding=%h, want 09", outstanding_o);
        else pass_cnt++;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk_cnt++;
        if (outstanding_o !== '0 || busy_o !== 1'b0)
            $display("FAIL mid_reset: outstanding=%h busy=%b, want 0/0", outstanding_o, busy_o);
        else pass_cnt++;
        be_rsp_valid_i = 1'b1;
        rsp_ready_i    = 2'b11;
        #1;
        chk_cnt++;
        if (be_rsp_ready_o !== 1'b0 || rsp_valid_o !== 2'b00)
            $display("FAIL stray_rsp: be_rsp_ready=%b rsp_valid=%b, want 0/00", be_rsp_ready_o, rsp_valid_o);
        else pass_cnt++;
        be_rsp_valid_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_stats();
        logic [31:0] want0;
`ifdef DMA_JOB_ARB_STATS_EN
        want0 = 32'd3;
`else
        want0 = 32'd0;
`endif
        for (int j = 0; j < 3; j++) begin
            issue_job(0);
            drain();
        end
        exp_q.delete();
        chk_cnt++;
        if (jobs_done_o[0 +: 32] !== want0 || jobs_done_o[32 +: 32] !== 32'd0)
            $display("FAIL jobs_done: req0=%0d req1=%0d, want %0d/0", jobs_done_o[0 +: 32], jobs_done_o[32 +: 32], want0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rr_alternate();
        test_hold();
        test_full();
        test_order();
        test_reset_midflight();
        test_stats();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
